xadc_drp_sched: RTL
===================

# xadc_drp_sched

Round-robin scheduler that shares the single XADC DRP port between several requesters, such as the bus-voltage sampler, a die-temperature monitor and PS-side register access. Each requester presents an address, write enable and write data. The scheduler grants one requester at a time, issues a single DRP access and returns the read data or a timeout error to the owning requester only. It sits in the clk_ctrl domain between the XADC wizard DRP pins and its clients.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYC, 64, maximum WAIT cycles before a transaction is aborted (≥4)

Ports:
- clk_ctrl  in  1  control clock, also the DRP clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  N_REQ  per-requester request level, held high until gnt
- req_addr  in  7*N_REQ  DRP address; requester i uses bits [7i+6:7i]
- req_we  in  N_REQ  1 = write, 0 = read
- req_di  in  16*N_REQ  write data; requester i uses bits [16i+15:16i]
- gnt  out  N_REQ  one-cycle, one-hot accept pulse
- rsp_valid  out  N_REQ  one-cycle, one-hot completion pulse to the owner
- rsp_data  out  16  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- drp_daddr  out  7  to XADC daddr_in
- drp_den  out  1  to XADC den_in
- drp_dwe  out  1  to XADC dwe_in
- drp_di  out  16  to XADC di_in
- drp_do  in  16  from XADC do_out
- drp_drdy  in  1  from XADC drdy_out
- busy  out  1  high in any state other than IDLE
- timeout_cnt  out  8  saturating count of timed-out transactions
- spurious_drdy  out  1  sticky; set by drp_drdy outside WAIT

## Operation
- The FSM has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any req bit is high, select the winner by round-robin, searching upward from ptr with wrap-around, then go to ISSUE. With no request, stay in IDLE.
- ptr resets to 0, so requester 0 has the highest priority after reset. After each grant, ptr = winner+1 mod N_REQ.
- ISSUE (exactly 1 cycle):
  - drp_den=1.
  - drp_daddr, drp_dwe and drp_di are taken from the winner's inputs as registered in IDLE.
  - gnt[winner]=1.
  - The timeout counter is cleared.
- WAIT:
  - drp_den=0; address and data outputs hold.
  - On drp_drdy, capture drp_do into rsp_data, set err=0 and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1 with no drdy, set rsp_data=16'h0000, err=1, increment timeout_cnt (saturating at 255) and go to RESP.
- RESP (1 cycle): rsp_valid[owner]=1 and rsp_err=err. rsp_data holds until the next capture.
- Writes complete identically. For writes, rsp_data carries whatever drp_do holds at drdy, and clients ignore it.
- drp_drdy in IDLE, ISSUE or RESP is ignored for data purposes and sets spurious_drdy. Only reset clears spurious_drdy.
- A req that drops before gnt is not serviced. If it drops in the cycle it was sampled in IDLE, the transaction still proceeds and completes normally.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.

## Timing
- Reset (asynchronous assert) forces:
  - state=IDLE, ptr=0
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0
  - drp_daddr=0, drp_den=0, drp_dwe=0, drp_di=0
  - busy=0, timeout_cnt=0, spurious_drdy=0
- Reset asserted mid-transaction abandons the transaction: no rsp_valid is issued, and drdy arriving after reset release sets spurious_drdy.
- Latency with req sampled in IDLE at edge k:
  - gnt and drp_den high during cycle k+1.
  - Earliest drdy is in cycle k+2.
  - rsp_valid in cycle k+3.
- A timeout transaction takes 1 + TIMEOUT_CYC + 1 cycles after IDLE.
- Minimum back-to-back period is 4 cycles per transaction; IDLE lasts one cycle between transactions.
- drdy arriving in the same cycle as the timeout terminal count counts as success: err=0, timeout_cnt unchanged.
- drp_den is never high for 2 consecutive cycles. At most one DRP access is outstanding at any time.

## Test plan
- Single read: req[0] with addr 7'h1D; XADC model returns 16'hABC0 one cycle after den → gnt[0] at k+1, rsp_valid[0] at k+3, rsp_data=16'hABC0, rsp_err=0.
- Fairness: req[0], req[1] and req[2] held high continuously → grant order 0,1,2,0,1,2 over 6 transactions, each gnt one-hot, 4-cycle period.
- Timeout: DRP model never asserts drdy → rsp_valid at 1+64+1 cycles after IDLE, rsp_err=1, rsp_data=0, timeout_cnt=1. Repeat 300 times → timeout_cnt=255.
- Simultaneous drdy and terminal count: drdy in the final WAIT cycle → err=0, data captured, timeout_cnt unchanged.
- Stray drdy: pulse drp_drdy while idle → spurious_drdy=1, no rsp_valid, state stays IDLE.
- Reset mid-WAIT: assert rst_n low during WAIT → all outputs at reset values immediately; after release, ptr=0 and a new req[2] transaction completes normally.

Source files
------------

// File: rtl/xadc_drp_sched_if.sv
`timescale 1ns/1ps
// Requester-side bus of the XADC DRP scheduler.
// Handshake: req[i] is a level held until gnt[i] pulses for one cycle; rsp_valid[i] then pulses once, with rsp_data/rsp_err valid in that cycle.
interface xadc_drp_sched_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req;
    logic [7*N_REQ-1:0]  req_addr;
    logic [N_REQ-1:0]    req_we;
    logic [16*N_REQ-1:0] req_di;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_data;
    logic                rsp_err;

    modport slave (
        input  req, req_addr, req_we, req_di,
        output gnt, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req, req_addr, req_we, req_di,
        input  gnt, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/xadc_drp_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one XADC DRP port between N_REQ requesters.
// One access in flight at a time; read data or a timeout flag returns only to the owner.
module xadc_drp_sched #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk_ctrl,
    input  logic                rst_n,
    xadc_drp_sched_if.slave     bus,
    output logic [6:0]          drp_daddr,
    output logic                drp_den,
    output logic                drp_dwe,
    output logic [15:0]         drp_di,
    input  logic [15:0]         drp_do,
    input  logic                drp_drdy,
    output logic                busy,
    output logic [7:0]          timeout_cnt,
    output logic                spurious_drdy,
    output logic [1:0]          state_dbg
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [N_REQ-1:0]  owner, owner_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_REQ-1:0]  gnt_n, rsp_valid_n;
    logic [15:0]       rsp_data_n, di_n;
    logic              rsp_err_n, den_n, dwe_n, spur_n;
    logic [6:0]        daddr_n;
    logic [7:0]        tcnt_n;

    logic              found;
    logic [PW-1:0]     win;
    logic [N_REQ-1:0]  win_oh;
    logic [6:0]        win_addr;
    logic              win_we;
    logic [15:0]       win_di;

    // Pass 0 scans ptr..N_REQ-1, pass 1 wraps to 0..ptr-1; first hit wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_oh   = '0;
        win_addr = '0;
        win_we   = 1'b0;
        win_di   = '0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && bus.req[j] && (p == 1 || PW'(j) >= ptr)) begin
                    found     = 1'b1;
                    win       = PW'(j);
                    win_oh[j] = 1'b1;
                    win_addr  = bus.req_addr[7*j +: 7];
                    win_we    = bus.req_we[j];
                    win_di    = bus.req_di[16*j +: 16];
                end
            end
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        cnt_n       = cnt;
        gnt_n       = '0;
        rsp_valid_n = '0;
        rsp_data_n  = bus.rsp_data;
        rsp_err_n   = bus.rsp_err;
        daddr_n     = drp_daddr;
        den_n       = 1'b0;
        dwe_n       = drp_dwe;
        di_n        = drp_di;
        tcnt_n      = timeout_cnt;
        spur_n      = spurious_drdy | (drp_drdy && state != S_WAIT);
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n = S_ISSUE;
                    owner_n = win_oh;
                    ptr_n   = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
                    gnt_n   = win_oh;
                    den_n   = 1'b1;
                    daddr_n = win_addr;
                    dwe_n   = win_we;
                    di_n    = win_di;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            S_WAIT: begin
                // drdy on the terminal-count cycle still counts as success.
                if (drp_drdy) begin
                    state_n     = S_RESP;
                    rsp_data_n  = drp_do;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = owner;
                end else if (cnt == CW'(TIMEOUT_CYC-1)) begin
                    state_n     = S_RESP;
                    rsp_data_n  = 16'h0000;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = owner;
                    tcnt_n      = (timeout_cnt == 8'hFF) ? timeout_cnt : timeout_cnt + 8'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            drp_daddr     <= '0;
            drp_den       <= 1'b0;
            drp_dwe       <= 1'b0;
            drp_di        <= '0;
            timeout_cnt   <= '0;
            spurious_drdy <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            owner         <= owner_n;
            cnt           <= cnt_n;
            bus.gnt       <= gnt_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_data  <= rsp_data_n;
            bus.rsp_err   <= rsp_err_n;
            drp_daddr     <= daddr_n;
            drp_den       <= den_n;
            drp_dwe       <= dwe_n;
            drp_di        <= di_n;
            timeout_cnt   <= tcnt_n;
            spurious_drdy <= spur_n;
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
endmodule
